pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage RISC-V pipeline with BTB. Drives the `en`/`clear` pairs of every segment register (IF, ID, EX, MEM, WB), the next-PC select, and three performance counters. It resolves load-use hazards, BTB mispredictions, JAL/JALR redirects and data-cache miss stalls. A small FSM sequences the reset flush and the multi-cycle miss wait.

## Interface
- `CNT_W`, default 32: performance counter width. Counters wrap modulo 2^CNT_W.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `Rs1D`, `Rs2D` in 5: source registers in ID.
- `RegReadD` in 2: operand usage in ID. Bit1 means rs1 is used, bit0 means rs2 is used.
- `JalD` in 1: JAL decoded in ID.
- `PredictedD` in 1: BTB predicted taken for the ID instruction.
- `RdE` in 5: destination register of the EX instruction.
- `MemToRegE` in 1: the EX instruction is a load.
- `BranchTypeE` in 3: non-zero means a conditional branch is in EX.
- `BranchE` in 1: branch resolved taken in EX.
- `PredictedE` in 1: BTB prediction carried with the EX instruction.
- `JalrE` in 1: JALR in EX.
- `DCacheMissM` in 1: level signal, MEM access missed.
- `DCacheReadyM` in 1: one-cycle pulse, miss refill done.
- `StallF` out 1: hold PC.
- `StallD`, `FlushD`, `StallE`, `FlushE`, `StallM`, `FlushM`, `StallW`, `FlushW` out 1: segment controls. Stall = `~en`, Flush = `clear`.
- `NpcSel` out 2: PC source. 0 = PC+4/BTB, 1 = BrNPC (taken target), 2 = PCE+4 (not-taken correction), 3 = JALR target.
- `BrCnt`, `MispCnt`, `StallCnt` out CNT_W: counters for branches executed, mispredictions, and miss-stall cycles.

## Operation
- FSM states:
  - S_RST: all Flush*=1, all Stall*=0, NpcSel=0. Always moves to S_RUN on the next cycle.
  - S_RUN: hazard resolution.
  - S_MISS: waiting for the refill.
- Transitions:
  - `rst` forces S_RST from any state, including mid-miss. `rst` also zeroes all counters.
  - S_RUN → S_MISS when `DCacheMissM`=1.
  - S_MISS → S_RUN on `DCacheReadyM`. `DCacheMissM` is ignored in the exit cycle.
- S_MISS outputs:
  - StallF, StallD, StallE, StallM = 1.
  - FlushW = 1, so a bubble enters WB.
  - All other controls = 0; NpcSel = 0.
  - No E-stage redirect is applied; the branch in EX stays frozen and resolves after exit.
- S_RUN hazard terms:
  - brE = (BranchTypeE≠0).
  - misp = brE & (BranchE≠PredictedE).
  - lu = MemToRegE & RdE≠0 & ((RegReadD[1] & Rs1D==RdE) | (RegReadD[0] & Rs2D==RdE)).
- S_RUN priority, highest first:
  1. JalrE: FlushD=FlushE=1, NpcSel=3.
  2. misp: FlushD=FlushE=1. NpcSel=1 if BranchE else 2.
  3. lu: StallF=StallD=1, FlushE=1.
  4. JalD & ~PredictedD: FlushD=1. NpcSel=0; the NPC generator selects the JAL target.
- A redirect coinciding with lu: the redirect wins, no stall is applied, and the dependent instruction is squashed.
- A correctly predicted branch produces no action.
- Counters:
  - BrCnt +1 per cycle with state=S_RUN & brE.
  - MispCnt +1 per cycle with state=S_RUN & misp.
  - StallCnt +1 per cycle in S_MISS, including the exit cycle.
  - All counters wrap at 2^CNT_W.

## Timing
- Controls and NpcSel are combinational from the current state and inputs, and must be valid before the `clk` edge in the same cycle.
- State and counters are registered and update on `posedge clk`.
- Reset values: state = S_RST; BrCnt = MispCnt = StallCnt = 0. Outputs in the cycle after `rst`: all Flush*=1, Stall*=0, NpcSel=0.
- Misprediction penalty: 2 cycles (the D and E bubbles).
- Load-use penalty: 1 cycle.
- Miss penalty: N+1 cycles, where N is the number of cycles before `DCacheReadyM`.
- If `DCacheMissM` and misp occur in the same S_RUN cycle:
  - The redirect is applied that cycle.
  - The FSM enters S_MISS on the next edge.
  - The misprediction is counted once.
- If `DCacheReadyM` and a new `DCacheMissM` occur in the same cycle in S_MISS, the FSM returns to S_RUN. Re-entry is decided on the following cycle.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum (S_RST, S_RUN, S_MISS);
  - the NpcSel encodings NPC_SEQ, NPC_BR, NPC_PC4, NPC_JALR.
- Sub-module `perf_counters` holds the three CNT_W wrapping counters, with sync clear and per-counter increment enables.
- The hazard logic stays flat in the top module.

## Test plan
- Reset: assert `rst` for 2 cycles mid-S_MISS → all Flush*=1 the following cycle, counters=0, state=S_RUN one cycle later.
- Load-use: MemToRegE=1, RdE=5, Rs1D=5, RegReadD=2'b10 → StallF=StallD=FlushE=1 for exactly one cycle. With RdE=0 → no stall.
- Misprediction:
  - BranchTypeE=1, BranchE=0, PredictedE=1 → FlushD=FlushE=1, NpcSel=2, MispCnt +1.
  - Same inputs with BranchE=1 → NpcSel=1.
  - BranchE=1, PredictedE=1 → no flush, only BrCnt +1.
- Priority: JalrE=1 together with lu=1 and misp=1 → NpcSel=3, FlushD=FlushE=1, StallF=0.
- Miss: DCacheMissM=1, DCacheReadyM pulses 4 cycles later → StallF/D/E/M=1 and FlushW=1 for 5 cycles, StallCnt=5. A branch held in EX meanwhile is counted only after exit.
- JAL: JalD=1, PredictedD=0 → FlushD=1 only. With PredictedD=1 → no action.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared FSM state and next-PC select encodings for the pipeline hazard controller.
// Pure type/constant definitions, no logic.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_MISS = 2'd2
  } state_e;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_PC4  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

endpackage

// File: rtl/perf_counters.sv
// Three wrapping performance counters with synchronous clear and per-counter enables.
// Counts update on the clock edge following an asserted enable.
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_inc,
  input  logic             misp_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] misp_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    br_cnt_d    = br_cnt_q;
    misp_cnt_d  = misp_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (br_inc)    br_cnt_d    = br_cnt_q + 1'b1;
    if (misp_inc)  misp_cnt_d  = misp_cnt_q + 1'b1;
    if (stall_inc) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q    <= '0;
      misp_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      misp_cnt_q  <= misp_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign br_cnt    = br_cnt_q;
  assign misp_cnt  = misp_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, mispredict, JAL/JALR, D-cache miss.
// Segment controls and NpcSel are combinational in the current cycle; state and counters are registered.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [1:0]       RegReadD,
  input  logic             JalD,
  input  logic             PredictedD,
  input  logic [4:0]       RdE,
  input  logic             MemToRegE,
  input  logic [2:0]       BranchTypeE,
  input  logic             BranchE,
  input  logic             PredictedE,
  input  logic             JalrE,
  input  logic             DCacheMissM,
  input  logic             DCacheReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             StallE,
  output logic             FlushE,
  output logic             StallM,
  output logic             FlushM,
  output logic             StallW,
  output logic             FlushW,
  output logic [1:0]       NpcSel,
  output logic [CNT_W-1:0] BrCnt,
  output logic [CNT_W-1:0] MispCnt,
  output logic [CNT_W-1:0] StallCnt
);

  state_e state_q, state_d;
  logic   br_e, misp, lu;

  assign br_e = (BranchTypeE != 3'd0);
  assign misp = br_e & (BranchE != PredictedE);
  assign lu   = MemToRegE & (RdE != 5'd0) &
                ((RegReadD[1] & (Rs1D == RdE)) | (RegReadD[0] & (Rs2D == RdE)));

  always_comb begin
    state_d = state_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    FlushD  = 1'b0;
    StallE  = 1'b0;
    FlushE  = 1'b0;
    StallM  = 1'b0;
    FlushM  = 1'b0;
    StallW  = 1'b0;
    FlushW  = 1'b0;
    NpcSel  = NPC_SEQ;
    case (state_q)
      S_RST: begin
        FlushD  = 1'b1;
        FlushE  = 1'b1;
        FlushM  = 1'b1;
        FlushW  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Any redirect squashes the dependent ID instruction, so it overrides a load-use stall.
        if (JalrE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
          NpcSel = NPC_JALR;
        end else if (misp) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
          NpcSel = BranchE ? NPC_BR : NPC_PC4;
        end else if (lu) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end else if (JalD & ~PredictedD) begin
          FlushD = 1'b1;
        end
        if (DCacheMissM) state_d = S_MISS;
      end
      S_MISS: begin
        // Everything up to MEM freezes; WB takes bubbles so retired results are not replayed.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
        if (DCacheReadyM) state_d = S_RUN;
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RST;
    else     state_q <= state_d;
  end

  perf_counters #(.CNT_W(CNT_W)) u_perf_counters (
    .clk       (clk),
    .rst       (rst),
    .br_inc    ((state_q == S_RUN) & br_e),
    .misp_inc  ((state_q == S_RUN) & misp),
    .stall_inc (state_q == S_MISS),
    .br_cnt    (BrCnt),
    .misp_cnt  (MispCnt),
    .stall_cnt (StallCnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed control vectors and counter values.
module tb_pipe_hazard_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    Rs1D, Rs2D, RdE;
  logic [1:0]    RegReadD;
  logic          JalD, PredictedD, MemToRegE, BranchE, PredictedE, JalrE;
  logic [2:0]    BranchTypeE;
  logic          DCacheMissM, DCacheReadyM;
  logic          StallF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW;
  logic [1:0]    NpcSel;
  logic [CW-1:0] BrCnt, MispCnt, StallCnt;

  int n_checks = 0;
  int n_fail   = 0;

  // {StallF,StallD,FlushD,StallE,FlushE,StallM,FlushM,StallW,FlushW,NpcSel}
  localparam logic [10:0] C_IDLE   = 11'b0_0_0_0_0_0_0_0_0_00;
  localparam logic [10:0] C_RST    = 11'b0_0_1_0_1_0_1_0_1_00;
  localparam logic [10:0] C_LU     = 11'b1_1_0_0_1_0_0_0_0_00;
  localparam logic [10:0] C_BR     = 11'b0_0_1_0_1_0_0_0_0_01;
  localparam logic [10:0] C_PC4    = 11'b0_0_1_0_1_0_0_0_0_10;
  localparam logic [10:0] C_JALR   = 11'b0_0_1_0_1_0_0_0_0_11;
  localparam logic [10:0] C_JAL    = 11'b0_0_1_0_0_0_0_0_0_00;
  localparam logic [10:0] C_MISS   = 11'b1_1_0_1_0_1_0_0_1_00;

  wire [10:0] ctl = {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushM,
                     StallW, FlushW, NpcSel};

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .RegReadD(RegReadD),
    .JalD(JalD), .PredictedD(PredictedD), .RdE(RdE), .MemToRegE(MemToRegE),
    .BranchTypeE(BranchTypeE), .BranchE(BranchE), .PredictedE(PredictedE),
    .JalrE(JalrE), .DCacheMissM(DCacheMissM), .DCacheReadyM(DCacheReadyM),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .StallE(StallE),
    .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM), .StallW(StallW),
    .FlushW(FlushW), .NpcSel(NpcSel), .BrCnt(BrCnt), .MispCnt(MispCnt),
    .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    Rs1D = 0; Rs2D = 0; RdE = 0; RegReadD = 0; JalD = 0; PredictedD = 0;
    MemToRegE = 0; BranchTypeE = 0; BranchE = 0; PredictedE = 0; JalrE = 0;
    DCacheMissM = 0; DCacheReadyM = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [1:0] rr);
    MemToRegE = 1; RdE = rd; Rs1D = rs1; Rs2D = rs2; RegReadD = rr;
  endtask

  task automatic set_br(input logic taken, input logic pred);
    BranchTypeE = 3'd1; BranchE = taken; PredictedE = pred;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0; #1;
    check("reset_ctl", 32'(ctl), 32'(C_RST));
    check("reset_brcnt", 32'(BrCnt), 0);
    check("reset_stallcnt", 32'(StallCnt), 0);
    tick(); #1;
    check("run_idle", 32'(ctl), 32'(C_IDLE));

    // load-use variants
    set_lu(5, 5, 0, 2'b10); #1;
    check("lu_rs1", 32'(ctl), 32'(C_LU));
    tick(); idle(); #1;
    check("lu_one_cycle", 32'(ctl), 32'(C_IDLE));
    set_lu(7, 1, 7, 2'b01); #1;
    check("lu_rs2", 32'(ctl), 32'(C_LU));
    set_lu(7, 7, 3, 2'b01); #1;
    check("lu_rs1_unused", 32'(ctl), 32'(C_IDLE));
    set_lu(0, 0, 0, 2'b11); #1;
    check("lu_rd0", 32'(ctl), 32'(C_IDLE));
    idle();

    // branches
    set_br(0, 1); #1;
    check("misp_nt", 32'(ctl), 32'(C_PC4));
    tick();
    check("misp_cnt1", 32'(MispCnt), 1);
    check("br_cnt1", 32'(BrCnt), 1);
    set_br(1, 0); #1;
    check("misp_t", 32'(ctl), 32'(C_BR));
    tick();
    set_br(1, 1); #1;
    check("br_correct", 32'(ctl), 32'(C_IDLE));
    tick();
    check("br_cnt3", 32'(BrCnt), 3);
    check("misp_cnt2", 32'(MispCnt), 2);

    // priority
    set_lu(5, 5, 0, 2'b10); set_br(0, 1); JalrE = 1; JalD = 1; #1;
    check("prio_jalr", 32'(ctl), 32'(C_JALR));
    JalrE = 0; #1;
    check("prio_misp_over_lu", 32'(ctl), 32'(C_PC4));
    tick();
    check("prio_br_cnt", 32'(BrCnt), 4);
    check("prio_misp_cnt", 32'(MispCnt), 3);
    idle();

    // JAL
    JalD = 1; PredictedD = 0; #1;
    check("jal_unpred", 32'(ctl), 32'(C_JAL));
    PredictedD = 1; #1;
    check("jal_pred", 32'(ctl), 32'(C_IDLE));
    PredictedD = 0; set_lu(9, 9, 0, 2'b10); #1;
    check("lu_over_jal", 32'(ctl), 32'(C_LU));
    idle();

    // miss coinciding with a misprediction, branch held in EX through the miss
    set_br(0, 1); DCacheMissM = 1; #1;
    check("miss_entry_redirect", 32'(ctl), 32'(C_PC4));
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("miss_wait%0d", i), 32'(ctl), 32'(C_MISS));
      tick();
    end
    DCacheReadyM = 1; #1;
    check("miss_exit_cycle", 32'(ctl), 32'(C_MISS));
    tick();
    DCacheReadyM = 0; DCacheMissM = 0;
    check("miss_stallcnt", 32'(StallCnt), 5);
    check("miss_br_frozen", 32'(BrCnt), 5);
    check("miss_misp_once", 32'(MispCnt), 4);
    set_br(1, 1); #1;
    check("miss_back_run", 32'(ctl), 32'(C_IDLE));
    tick();
    check("br_after_exit", 32'(BrCnt), 6);

    // counter wrap at 2^CW
    for (int i = 0; i < 3; i++) tick();
    check("br_wrap", 32'(BrCnt), 1);
    idle();

    // re-enter miss then reset in the middle of it
    DCacheMissM = 1; #1;
    check("reenter_run", 32'(ctl), 32'(C_IDLE));
    tick(); #1;
    check("reenter_miss", 32'(ctl), 32'(C_MISS));
    rst = 1;
    tick(); tick();
    rst = 0; DCacheMissM = 0; #1;
    check("rst_mid_miss_ctl", 32'(ctl), 32'(C_RST));
    check("rst_mid_miss_br", 32'(BrCnt), 0);
    check("rst_mid_miss_misp", 32'(MispCnt), 0);
    check("rst_mid_miss_stall", 32'(StallCnt), 0);
    tick(); #1;
    check("rst_then_run", 32'(ctl), 32'(C_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
